// File: rtl/fadd_pkg.sv
// Shared types and helpers for the pipelined single-precision adder.
package fadd_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } float32_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'd255;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fclass_e;

    // Denormals carry no weight inside the adder; keep only the sign.
    function automatic float32_t flush_denorm(input float32_t f);
        float32_t r;
        r = f;
        if (f.exp == 8'd0) begin
            r.man = 23'd0;
        end else begin
            r.man = f.man;
        end
        return r;
    endfunction

    function automatic fclass_e classify(input float32_t f);
        fclass_e c;
        if (f.exp == 8'd0) begin
            c = CLS_ZERO;
        end else if (f.exp != EXP_MAX) begin
            c = CLS_NORM;
        end else if (f.man == 23'd0) begin
            c = CLS_INF;
        end else begin
            c = CLS_NAN;
        end
        return c;
    endfunction

endpackage

// File: rtl/fadd_pipe_fadd.sv
// Combinational float32 adder, round-to-nearest-even. Operands must be normal or zero;
// results below the normal range flush to signed zero, overflow reports exponent 255.
module fadd
    import fadd_pkg::*;
(
    input  float32_t    a_i,
    input  float32_t    b_i,
    output logic [31:0] y_o
);

    logic        swap_s, big_sign_s, eff_sub_s, rnd_up_s;
    logic [30:0] big_mag_s, sml_mag_s;
    logic [7:0]  d_s;
    logic [26:0] mb_x_s, ms_x_s, ms_sh_s, lost_s, norm_s;
    logic [27:0] sum_s;
    logic [4:0]  lz_s;
    logic [9:0]  exp_n_s, exp_r_s;
    logic [24:0] mr_s;

    assign swap_s     = b_i[30:0] > a_i[30:0];
    assign big_mag_s  = swap_s ? b_i[30:0] : a_i[30:0];
    assign sml_mag_s  = swap_s ? a_i[30:0] : b_i[30:0];
    assign big_sign_s = swap_s ? b_i.sign : a_i.sign;
    assign eff_sub_s  = a_i.sign ^ b_i.sign;
    assign d_s        = big_mag_s[30:23] - sml_mag_s[30:23];
    assign mb_x_s     = {(big_mag_s[30:23] != 8'd0), big_mag_s[22:0], 3'b000};
    assign ms_x_s     = {(sml_mag_s[30:23] != 8'd0), sml_mag_s[22:0], 3'b000};

    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    always_comb begin
        lost_s  = 27'd0;
        ms_sh_s = 27'd0;
        if (d_s >= 8'd27) begin
            ms_sh_s = {26'd0, |ms_x_s};
        end else begin
            lost_s  = ms_x_s & ((27'd1 << d_s) - 27'd1);
            ms_sh_s = (ms_x_s >> d_s) | {26'd0, |lost_s};
        end
    end

    assign sum_s = eff_sub_s ? ({1'b0, mb_x_s} - {1'b0, ms_sh_s})
                             : ({1'b0, mb_x_s} + {1'b0, ms_sh_s});

    // Normalize: one right shift on carry-out, otherwise left by leading-zero count.
    always_comb begin
        lz_s    = 5'd0;
        norm_s  = sum_s[26:0];
        exp_n_s = {2'b00, big_mag_s[30:23]};
        if (sum_s[27]) begin
            norm_s  = {sum_s[27:2], sum_s[1] | sum_s[0]};
            exp_n_s = {2'b00, big_mag_s[30:23]} + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (sum_s[i]) begin
                    lz_s = 5'(26 - i);
                end else begin
                    lz_s = lz_s;
                end
            end
            norm_s  = sum_s[26:0] << lz_s;
            exp_n_s = {2'b00, big_mag_s[30:23]} - {5'd0, lz_s};
        end
    end

    assign rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    assign mr_s     = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
    assign exp_r_s  = exp_n_s + {9'd0, mr_s[24]};

    // Pack the result; exact cancellation yields +0 unless both inputs were -0.
    always_comb begin
        y_o = 32'd0;
        if (sum_s == 28'd0) begin
            y_o = {a_i.sign & b_i.sign, 31'd0};
        end else if (exp_r_s[9] || (exp_r_s == 10'd0)) begin
            y_o = {big_sign_s, 31'd0};
        end else if (exp_r_s >= 10'd255) begin
            y_o = {big_sign_s, EXP_MAX, 23'd0};
        end else begin
            y_o = {big_sign_s, exp_r_s[7:0], (mr_s[24] ? mr_s[23:1] : mr_s[22:0])};
        end
    end

endmodule

// File: rtl/fadd_pipe.sv
// Two-stage valid/ready pipeline around fadd with sticky overflow/invalid flags.
// Define FADD_PIPE_SPECIAL_EN to classify Inf/NaN operands in S1 and bypass the adder.
module fadd_pipe
    import fadd_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_ovf,
    output logic             flag_inv,
    input  logic             flag_clr
);

    float32_t         x1_s, x2_s, s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, tag_q, tag_d;
    logic [31:0]      y_q, y_d, y_add_s, res_y_s;
    logic             ovf_q, ovf_d, res_ovf_s, res_inv_s;
    logic             s1_adv_s, s1_load_s, s2_load_s;

    assign x1_s      = in_x1;
    assign x2_s      = {in_x2[31] ^ in_sub, in_x2[30:0]};
    assign s1_adv_s  = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s1_adv_s;
    assign s1_load_s = in_valid && in_ready;
    assign s2_load_s = s1_valid_q && s1_adv_s;

    fadd u_fadd (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .y_o (y_add_s)
    );

`ifdef FADD_PIPE_SPECIAL_EN
    fclass_e     c1_s, c2_s;
    logic        byp_s, byp_d, s1_byp_q, inv_s, s1_inv_q, inv_q, inv_d;
    logic [31:0] byp_y_s, s1_byp_y_q, byp_y_d;

    assign c1_s = classify(x1_s);
    assign c2_s = classify(x2_s);

    // Operand classification: NaN dominates, opposite infinities are invalid.
    always_comb begin
        byp_s   = 1'b1;
        inv_s   = 1'b0;
        byp_y_s = 32'd0;
        if ((c1_s == CLS_NAN) || (c2_s == CLS_NAN)) begin
            byp_y_s = QNAN;
        end else if ((c1_s == CLS_INF) && (c2_s == CLS_INF) && (x1_s.sign != x2_s.sign)) begin
            byp_y_s = QNAN;
            inv_s   = 1'b1;
        end else if (c1_s == CLS_INF) begin
            byp_y_s = x1_s;
        end else if (c2_s == CLS_INF) begin
            byp_y_s = x2_s;
        end else begin
            byp_s = 1'b0;
        end
    end

    assign byp_d     = s1_load_s ? byp_s   : s1_byp_q;
    assign byp_y_d   = s1_load_s ? byp_y_s : s1_byp_y_q;
    assign inv_d     = (s1_load_s ? inv_s  : s1_inv_q);
    assign res_inv_s = s1_byp_q && s1_inv_q;
    assign flag_inv  = inv_q;

    // Bypass-path state for the special-operand classification.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_byp_q   <= 1'b0;
            s1_byp_y_q <= 32'd0;
            s1_inv_q   <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            s1_byp_q   <= byp_d;
            s1_byp_y_q <= byp_y_d;
            s1_inv_q   <= inv_d;
            inv_q      <= (inv_q && !flag_clr) || (s2_load_s && res_inv_s);
        end
    end
`else
    assign res_inv_s = 1'b0;
    assign flag_inv  = res_inv_s;
`endif

    // Result selection: adder overflow saturates to a clean signed infinity.
    always_comb begin
        res_ovf_s = 1'b0;
        res_y_s   = y_add_s;
`ifdef FADD_PIPE_SPECIAL_EN
        if (s1_byp_q) begin
            res_y_s = s1_byp_y_q;
        end else
`endif
        if (y_add_s[30:23] == EXP_MAX) begin
            res_ovf_s = 1'b1;
            res_y_s   = {y_add_s[31], EXP_MAX, 23'd0};
        end else begin
            res_y_s = y_add_s;
        end
    end

    // Next state: S1 refills whenever it is free or draining, S2 holds under backpressure.
    always_comb begin
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_a_d     = s1_load_s ? flush_denorm(x1_s) : s1_a_q;
        s1_b_d     = s1_load_s ? flush_denorm(x2_s) : s1_b_q;
        s1_tag_d   = s1_load_s ? in_tag : s1_tag_q;
        s2_valid_d = s1_adv_s ? s1_valid_q : s2_valid_q;
        y_d        = s2_load_s ? res_y_s : y_q;
        tag_d      = s2_load_s ? s1_tag_q : tag_q;
        ovf_d      = (ovf_q && !flag_clr) || (s2_load_s && res_ovf_s);
    end

    // Pipeline and sticky-flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= 32'd0;
            tag_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            tag_q      <= tag_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = y_q;
    assign out_tag   = tag_q;
    assign flag_ovf  = ovf_q;

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed and randomized checks of fadd_pipe against an exact-integer float32 adder model.
module tb_fadd_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_x1, in_x2;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic        flag_ovf, flag_inv, flag_clr;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;
    bit exp_ovf_sticky = 1'b0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    fadd_pipe #(.TAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .flag_ovf(flag_ovf), .flag_inv(flag_inv),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact value arithmetic on wide integers, then one RNE rounding.
    function automatic logic [32:0] ref_add(input logic [31:0] x1, input logic [31:0] x2,
                                            input logic sub);
        logic s1, s2, sg;
        int e1, e2, emin, p, e, sh;
        logic [299:0] a, b, s, q, rem, half;
        s1 = x1[31];
        s2 = x2[31] ^ sub;
        e1 = int'(x1[30:23]);
        e2 = int'(x2[30:23]);
`ifdef FADD_PIPE_SPECIAL_EN
        if ((e1 == 255 && x1[22:0] != 0) || (e2 == 255 && x2[22:0] != 0))
            return {1'b0, 32'h7FC0_0000};
        if (e1 == 255 && e2 == 255 && s1 != s2) return {1'b0, 32'h7FC0_0000};
        if (e1 == 255) return {1'b0, s1, 8'hFF, 23'd0};
        if (e2 == 255) return {1'b0, s2, 8'hFF, 23'd0};
`endif
        if (e1 == 0 && e2 == 0) return {1'b0, s1 & s2, 31'd0};
        if (e1 == 0) return {1'b0, s2, x2[30:0]};
        if (e2 == 0) return {1'b0, s1, x1[30:0]};
        emin = (e1 < e2) ? e1 : e2;
        a = 300'({1'b1, x1[22:0]}) << (e1 - emin);
        b = 300'({1'b1, x2[22:0]}) << (e2 - emin);
        if (s1 == s2) begin s = a + b; sg = s1; end
        else if (a > b) begin s = a - b; sg = s1; end
        else if (b > a) begin s = b - a; sg = s2; end
        else return {1'b0, 32'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        e = emin + p - 23;
        if (p > 23) begin
            sh = p - 23;
            q = s >> sh;
            rem = s - (q << sh);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 300'd1;
            if (q[24]) begin q = q >> 1; e++; end
        end else begin
            q = s << (23 - p);
        end
        if (e >= 255) return {1'b1, sg, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, sg, 31'd0};
        return {1'b0, sg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f(input logic [7:0] near, input bit use_near);
        int e;
        int r;
        r = int'($urandom_range(0, 11));
        if (use_near) begin
            e = int'(near) + int'($urandom_range(0, 4)) - 2;
        end else if (r == 0) begin
            e = 0;
        end else if (r == 1) begin
            e = 254 - int'($urandom_range(0, 1));
        end else begin
            e = int'($urandom_range(1, 254));
        end
        if (use_near && e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    // Scoreboard: record accepted ops, compare every consumed result in order.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t ex;
                    ex = exp_q.pop_front();
                    chk("rand_y", out_y, ex.y);
                    chk("rand_tag", 32'(out_tag), 32'(ex.tag));
                    if (ex.ovf) exp_ovf_sticky = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_t ex;
                logic [32:0] r;
                r = ref_add(in_x1, in_x2, in_sub);
                ex.y = r[31:0];
                ex.ovf = r[32];
                ex.tag = in_tag;
                exp_q.push_back(ex);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] x1, input logic [31:0] x2, input logic sub,
                         input logic [3:0] tag);
        in_valid = 1'b1; in_x1 = x1; in_x2 = x2; in_sub = sub; in_tag = tag;
    endtask

    // Single op with out_ready high: result must appear exactly two cycles after accept.
    task automatic do_op(input string name, input logic [31:0] x1, input logic [31:0] x2,
                         input logic sub, input logic [3:0] tag, input logic [31:0] y_exp);
        out_ready = 1'b1;
        offer(x1, x2, sub, tag);
        @(negedge clk);
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_y"}, out_y, y_exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_x1 = 32'd0; in_x2 = 32'd0;
        in_tag = 4'd0; out_ready = 1'b1; flag_clr = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", {30'd0, flag_ovf, flag_inv}, 32'd0);
        step();
        rstn = 1'b1;
        step();

        do_op("add_1_1", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd5, 32'h4000_0000);
        do_op("sub_3_1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd6, 32'h4000_0000);
        do_op("sub_1_1", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd7, 32'h0000_0000);
        do_op("denorm", 32'h0000_0001, 32'h3F80_0000, 1'b0, 4'd8, 32'h3F80_0000);
        chk("no_ovf_yet", 32'(flag_ovf), 32'd0);

        do_op("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd9, 32'h7F80_0000);
        chk("ovf_flag", 32'(flag_ovf), 32'd1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(flag_ovf), 32'd0);
        step();

        // Overflow result reaches S2 on the same edge flag_clr is high.
        offer(32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 4'd10);
        step();
        in_valid = 1'b0;
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        @(negedge clk);
        chk("set_wins", 32'(flag_ovf), 32'd1);
        chk("neg_inf", out_y, 32'hFF80_0000);
        step();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;

`ifdef FADD_PIPE_SPECIAL_EN
        do_op("inf_m_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd11, 32'h7FC0_0000);
        chk("inv_flag", 32'(flag_inv), 32'd1);
        do_op("nan", 32'h7FA0_0001, 32'h3F80_0000, 1'b0, 4'd12, 32'h7FC0_0000);
        do_op("inf_fin", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 4'd13, 32'hFF80_0000);
        chk("inf_no_ovf", 32'(flag_ovf), 32'd0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
`else
        chk("inv_tied", 32'(flag_inv), 32'd0);
`endif

        // Backpressure: two ops fill the pipe, the third waits until the output drains.
        out_ready = 1'b0;
        offer(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd0);
        @(negedge clk);
        chk("bp_acc0", 32'(in_ready), 32'd1);
        step();
        offer(32'h4000_0000, 32'h3F80_0000, 1'b0, 4'd1);
        @(negedge clk);
        chk("bp_acc1", 32'(in_ready), 32'd1);
        step();
        offer(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_tag", 32'(out_tag), 32'd0);
            chk("bp_hold_y", out_y, 32'h4000_0000);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_swap_ready", 32'(in_ready), 32'd1);
        chk("bp_tag0", 32'(out_tag), 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_v1", 32'(out_valid), 32'd1);
        chk("bp_tag1", 32'(out_tag), 32'd1);
        chk("bp_y1", out_y, 32'h4040_0000);
        step();
        @(negedge clk);
        chk("bp_v2", 32'(out_valid), 32'd1);
        chk("bp_tag2", 32'(out_tag), 32'd2);
        chk("bp_y2", out_y, 32'h4000_0000);
        step();
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);
        step();

        // Reset with two ops in flight, one of them overflowing.
        out_ready = 1'b0;
        offer(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd3);
        step();
        offer(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd4);
        step();
        in_valid = 1'b0;
        chk("pre_rst_ovf", 32'(flag_ovf), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_flags", {30'd0, flag_ovf, flag_inv}, 32'd0);
        chk("mid_rst_y", out_y, 32'd0);
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Randomized traffic with random backpressure against the model.
        mon_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bit acc;
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            a = rnd_f(8'd0, 1'b0);
            offer(a, rnd_f(a[30:23], ($urandom_range(0, 1) == 1)), 1'($urandom_range(0, 1)),
                  4'(k));
            out_ready = ($urandom_range(0, 3) != 0);
            acc = 1'b0;
            for (int c = 0; c < 50 && !acc; c++) begin
                @(negedge clk);
                acc = in_ready;
                step();
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand_ovf_sticky", 32'(flag_ovf), 32'(exp_ovf_sticky));
        chk("rand_inv", 32'(flag_inv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fadd_pipe.md
FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 Parameter: TAG_W, 4, width of the opaque tag carried alongside each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation offered.
REQ-005 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 in_sub  input  1  1 = x1 - x2, 0 = x1 + x2.
REQ-007 in_x1, in_x2  input  32  IEEE-754 single operands.
REQ-008 in_tag  input  TAG_W  returned unchanged with result.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 out_y  output  32  single-precision result.
REQ-012 out_tag  output  TAG_W  tag of the op producing out_y.
REQ-013 flag_ovf, flag_inv  output  1  sticky overflow / invalid flags.
REQ-014 flag_clr  input  1  synchronous clear of both sticky flags.

Function
REQ-015 Two-stage pipeline: S1 registers operands; S2 registers fadd output; each stage has one valid bit.
REQ-016 Accepted op SHALL appear on out_valid exactly 2 cycles after acceptance when out_ready held high.
REQ-017 Throughput: one op/cycle with out_ready high; in_ready = !s1_valid || s1 advancing.
REQ-018 S1 advances when !s2_valid || out_ready; S2 holds out_y/out_tag stable while out_valid && !out_ready.
REQ-019 Full pipeline (both stages valid, out_ready low) SHALL drive in_ready low; no op dropped, duplicated or reordered.
REQ-020 Simultaneous consume at output and accept at input when full SHALL be permitted (no bubble).
REQ-021 Subtraction: S1 SHALL store x2 with sign bit inverted; fadd always performs addition.
REQ-022 Arithmetic core is the existing combinational fadd, driven from S1 registers, round-to-nearest-even.
REQ-023 Denormal operands SHALL be flushed to signed zero in S1 before entering fadd.
REQ-024 Result exponent 255 from fadd SHALL yield ±Inf (mantissa 0) and set flag_ovf when captured in S2.
REQ-025 Flags set on the cycle the offending result enters S2; flag_clr and a simultaneous set -> set wins.

Reset
REQ-026 rstn low SHALL asynchronously clear s1_valid, s2_valid, flag_ovf, flag_inv; out_y and out_tag reset to 0; in_ready reads 1 after reset.
REQ-027 Reset mid-operation discards all in-flight ops; no out_valid until a new op is accepted after release.

Configuration
REQ-028 Macro FADD_PIPE_SPECIAL_EN: when defined, S1 classifies operands and bypasses fadd: any NaN -> 0x7FC00000; Inf + opposite Inf -> 0x7FC00000 and flag_inv; Inf + finite/same-sign Inf -> that Inf.
REQ-029 Without FADD_PIPE_SPECIAL_EN: no classification, all operands go through fadd, flag_inv tied 0.

Structure
REQ-030 Shared package fadd_pkg: float32 struct typedef {sign, exp[7:0], man[22:0]}, constants QNAN (0x7FC00000), EXP_MAX (255), special-class enum.
REQ-031 One sub-module instance: fadd (existing adder); no other sub-modules.

Verification
REQ-032 0x3F800000 + 0x3F800000, out_ready=1 -> out_y=0x40000000 at cycle 2 after accept, tag echoed.
REQ-033 in_sub=1, 0x40400000 - 0x3F800000 -> 0x40000000; 0x3F800000 - 0x3F800000 -> 0x00000000.
REQ-034 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flag_ovf=1; flag_clr pulse -> flag_ovf=0 next cycle.
REQ-035 SPECIAL_EN: 0x7F800000 + 0xFF800000 -> 0x7FC00000, flag_inv=1; 0x00000001 + 0x3F800000 -> 0x3F800000.
REQ-036 out_ready=0 for 5 cycles, 3 ops offered -> 2 accepted, in_ready low; release -> tags 0,1,2 in order, one per cycle.
REQ-037 rstn pulsed with 2 ops in flight -> out_valid=0, flags 0, no stale result after reset release.
